bellek_birimi: RTL and testbench
================================

# bellek_birimi

Word-addressed program/data memory that serves as the responder on the core's `bellek_*` port. It holds the core in reset while a program image is streamed in over a valid/ready load port, then releases the core and serves single-cycle reads and writes. Out-of-range accesses are flagged. It sits between the testbench or boot loader and `islemci`.

## Interface
- `BELLEK_ADRES`, default 32'h8000_0000: byte address of word 0.
- `KELIME_SAYISI`, default 1024: capacity in 32-bit words; a power of two and ≥ 2.
- `VERI_BIT`, default 32: data width.
- `ADRES_BIT`, default 32: address width.
- `SAYAC_BIT`, default $clog2(KELIME_SAYISI)+1: width of the load counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; **synchronous, active-low**.
- `bellek_adres`  in  ADRES_BIT  byte address driven by the core.
- `bellek_oku_veri`  out  VERI_BIT  read data, combinational from `bellek_adres`.
- `bellek_yaz_veri`  in  VERI_BIT  write data from the core.
- `bellek_yaz`  in  1  write strobe from the core.
- `yukle_gecerli`  in  1  load word valid.
- `yukle_veri`  in  VERI_BIT  load word.
- `yukle_son`  in  1  marks the last load word; meaningful only while `yukle_gecerli`=1.
- `yukle_hazir`  out  1  load port ready.
- `islemci_rst`  out  1  active-high reset to the core; registered.
- `yuklenen_kelime`  out  SAYAC_BIT  number of words accepted since reset.
- `adres_hata`  out  1  sticky out-of-range flag.
- `hata_adres`  out  ADRES_BIT  address of the first out-of-range access.

## Operation
- **Reset values** (when `rst`=0 at an edge):
  - state = YUKLE, `yukle_hazir`=1, `islemci_rst`=1.
  - `yuklenen_kelime`=0, `adres_hata`=0, `hata_adres`=0.
  - Memory contents are not cleared.
- **Address decode**: `idx = (bellek_adres − BELLEK_ADRES) >> 2`. An address is in range iff `BELLEK_ADRES ≤ bellek_adres < BELLEK_ADRES + 4·KELIME_SAYISI`. Bits [1:0] are ignored; misalignment is not an error.
- **Read**: `bellek_oku_veri` = `mem[idx]` when the address is in range, otherwise 0. Reads are valid in every state.
- **FSM**:
  - YUKLE:
    - A word is accepted on an edge with `yukle_gecerli` & `yukle_hazir`; it is written to `mem[yuklenen_kelime]` and the counter increments.
    - Accepting a word with `yukle_son`=1, or accepting the word at index KELIME_SAYISI−1, moves the FSM to BIRAK. No wrap-around: excess words are never accepted.
    - Core writes (`bellek_yaz`) are ignored in this state.
  - BIRAK: one cycle. `yukle_hazir`=0, `islemci_rst`=1. Always moves to CALIS.
  - CALIS:
    - `islemci_rst`=0 and `yukle_hazir`=0; the load port is ignored.
    - `bellek_yaz`=1 with an in-range address writes `mem[idx]` ← `bellek_yaz_veri`.
    - CALIS is left only by reset.
- **Error capture**: only in CALIS. At any edge where `bellek_adres` is out of range (read or write), set `adres_hata`. If it was 0, also capture `hata_adres` ← `bellek_adres`. Later faults do not update `hata_adres`. Out-of-range writes are dropped.
- **Reset mid-load**: the load restarts at index 0. Words already written remain in memory but are overwritten by the new stream.

## Timing
- Read latency is zero (combinational). The core samples read data at the edge following its address update.
- A write becomes visible on `bellek_oku_veri` immediately after the writing edge. A same-cycle read returns the old data.
- Load throughput: one word per cycle. `yukle_hazir` stays high through YUKLE, including the cycle in which the last word is accepted.
- If the last word is accepted at edge E:
  - BIRAK holds from E to E+1.
  - `islemci_rst` falls after E+1.
  - The core's first non-reset edge is E+2, and it fetches from `BELLEK_ADRES`.
- `islemci_rst` is high for every edge from reset through BIRAK, so the core re-initializes its PC at least once.

## Structure
- Package `bellek_paket`: `BELLEK_ADRES` default and the state encoding (YUKLE=2'd0, BIRAK=2'd1, CALIS=2'd2).
- Sub-module `bellek_dizisi`: single write port, asynchronous read, depth KELIME_SAYISI. Its write address and data are muxed between the load path (YUKLE) and the core path (CALIS). The FSM, counter, decode, and error logic stay in `bellek_birimi`.

## Test plan
- **Load then run**: stream 4 words with `yukle_son` on the 4th. Expect `yuklenen_kelime`=4, `islemci_rst` low two edges after the last accept, and a read of 0x8000_0008 returning word 2.
- **Backpressure and gaps**: toggle `yukle_gecerli` randomly for 10 words. Expect exactly 10 accepts, in order, with no duplicates.
- **Overflow**: with KELIME_SAYISI=8, offer 12 words without `yukle_son`. Expect 8 accepted, `yukle_hazir`=0 after the 8th, `yuklenen_kelime`=8.
- **Core write/read**: in CALIS, write 0xDEAD_BEEF to 0x8000_0010. The next-cycle read returns 0xDEAD_BEEF. A `bellek_yaz` issued during YUKLE leaves memory unchanged.
- **Errors**: in CALIS, access 0x7FFF_FFFC and then 0x9000_0000. Expect `adres_hata`=1, `hata_adres`=0x7FFF_FFFC, read data 0, memory unchanged.
- **Reset mid-load**: after 3 words, pulse `rst`=0 for one edge, then load 2 words. Expect `yuklenen_kelime`=2, `adres_hata`=0, and words 0–1 replaced.

Source files
------------

// File: rtl/bellek_paket.sv
// bellek_paket: shared definitions for the bellek_birimi memory block.
//   VARSAYILAN_BELLEK_ADRES : default byte address of word 0
//   durum_t                 : load/release/run state encoding
package bellek_paket;

    localparam logic [31:0] VARSAYILAN_BELLEK_ADRES = 32'h8000_0000;

    typedef enum logic [1:0] {
        Yukle = 2'd0,  // accepting the program image, core held in reset
        Birak = 2'd1,  // one-cycle release step
        Calis = 2'd2   // core running, serving reads and writes
    } durum_t;

endpackage

// File: rtl/bellek_birimi_if.sv
// bellek_birimi_if: core bus plus program-load port of bellek_birimi.
//   bellek_adres / bellek_oku_veri / bellek_yaz_veri / bellek_yaz : core access
//   yukle_gecerli / yukle_veri / yukle_son / yukle_hazir           : load stream
// master = core side / boot loader, slave = the memory.
interface bellek_birimi_if
    import bellek_paket::*;
#(
    parameter int unsigned ADRES_BIT = 32,
    parameter int unsigned VERI_BIT  = 32
) ();

    logic [ADRES_BIT-1:0] bellek_adres;
    logic [VERI_BIT-1:0]  bellek_oku_veri;
    logic [VERI_BIT-1:0]  bellek_yaz_veri;
    logic                 bellek_yaz;
    logic                 yukle_gecerli;
    logic [VERI_BIT-1:0]  yukle_veri;
    logic                 yukle_son;
    logic                 yukle_hazir;

    modport master (
        output bellek_adres, bellek_yaz_veri, bellek_yaz,
        output yukle_gecerli, yukle_veri, yukle_son,
        input  bellek_oku_veri, yukle_hazir
    );

    modport slave (
        input  bellek_adres, bellek_yaz_veri, bellek_yaz,
        input  yukle_gecerli, yukle_veri, yukle_son,
        output bellek_oku_veri, yukle_hazir
    );

endinterface

// File: rtl/bellek_dizisi.sv
// bellek_dizisi: word storage with one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk       : clock
//   yaz       : write enable
//   yaz_adres : write word index
//   yaz_veri  : write data
//   oku_adres : read word index
//   oku_veri  : read data (combinational)
module bellek_dizisi
    import bellek_paket::*;
#(
    parameter int unsigned DERINLIK = 1024,
    parameter int unsigned VERI_BIT = 32,
    parameter int unsigned IDX_BIT  = $clog2(DERINLIK)
) (
    input  logic                clk,
    input  logic                yaz,
    input  logic [IDX_BIT-1:0]  yaz_adres,
    input  logic [VERI_BIT-1:0] yaz_veri,
    input  logic [IDX_BIT-1:0]  oku_adres,
    output logic [VERI_BIT-1:0] oku_veri
);

    logic [VERI_BIT-1:0] mem [DERINLIK];

    always_ff @(posedge clk) begin
        if (yaz) begin
            mem[yaz_adres] <= yaz_veri;
        end
    end

    assign oku_veri = mem[oku_adres];

endmodule

// File: rtl/bellek_birimi.sv
// bellek_birimi: program/data memory responding to the core. Holds the core in
// reset while a program image streams in, then serves single-cycle accesses.
//   clk             : clock
//   rst             : synchronous active-low reset
//   bus             : core bus and load port (slave side)
//   islemci_rst     : registered active-high reset to the core
//   yuklenen_kelime : words accepted since reset
//   adres_hata      : sticky out-of-range flag (set only while running)
//   hata_adres      : address of the first out-of-range access
module bellek_birimi
    import bellek_paket::*;
#(
    parameter int unsigned          ADRES_BIT     = 32,
    parameter int unsigned          VERI_BIT      = 32,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES  = ADRES_BIT'(VARSAYILAN_BELLEK_ADRES),
    parameter int unsigned          KELIME_SAYISI = 1024,
    parameter int unsigned          SAYAC_BIT     = $clog2(KELIME_SAYISI) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bellek_birimi_if.slave       bus,
    output logic                 islemci_rst,
    output logic [SAYAC_BIT-1:0] yuklenen_kelime,
    output logic                 adres_hata,
    output logic [ADRES_BIT-1:0] hata_adres
);

    localparam int unsigned          IDX_BIT    = $clog2(KELIME_SAYISI);
    localparam logic [ADRES_BIT-1:0] BOYUT_BAYT = ADRES_BIT'(KELIME_SAYISI * 4);
    localparam logic [SAYAC_BIT-1:0] SON_IDX    = SAYAC_BIT'(KELIME_SAYISI - 1);

    durum_t               durum_q, durum_d;
    logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
    logic                 hata_q, hata_d;
    logic [ADRES_BIT-1:0] hata_adres_q, hata_adres_d;
    logic                 islemci_rst_q;

    logic [ADRES_BIT-1:0] ofset;
    logic                 aralikta;
    logic [IDX_BIT-1:0]   idx;
    logic                 kabul;

    logic                 dizi_yaz;
    logic [IDX_BIT-1:0]   dizi_yaz_adres;
    logic [VERI_BIT-1:0]  dizi_yaz_veri;
    logic [VERI_BIT-1:0]  dizi_oku_veri;

    // The lower-bound test guards against wrap-around of the subtraction.
    assign ofset    = bus.bellek_adres - BELLEK_ADRES;
    assign aralikta = (bus.bellek_adres >= BELLEK_ADRES) && (ofset < BOYUT_BAYT);
    assign idx      = ofset[IDX_BIT+1:2];

    assign kabul = bus.yukle_gecerli && (durum_q == Yukle);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            durum_q       <= Yukle;
            sayac_q       <= '0;
            hata_q        <= 1'b0;
            hata_adres_q  <= '0;
            islemci_rst_q <= 1'b1;
        end else begin
            durum_q       <= durum_d;
            sayac_q       <= sayac_d;
            hata_q        <= hata_d;
            hata_adres_q  <= hata_adres_d;
            // Core reset drops on the same edge that enters Calis.
            islemci_rst_q <= (durum_d != Calis);
        end
    end

    // Next-state logic.
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            Yukle: begin
                // Last slot ends the load even without yukle_son; no wrap.
                if (kabul && (bus.yukle_son || (sayac_q == SON_IDX))) begin
                    durum_d = Birak;
                end
            end
            Birak:   durum_d = Calis;
            Calis:   durum_d = Calis;
            default: durum_d = Yukle;
        endcase
    end

    // Outputs, write-port mux, counter and error capture.
    always_comb begin
        bus.yukle_hazir = 1'b0;
        dizi_yaz        = 1'b0;
        dizi_yaz_adres  = idx;
        dizi_yaz_veri   = bus.bellek_yaz_veri;
        sayac_d         = sayac_q;
        hata_d          = hata_q;
        hata_adres_d    = hata_adres_q;
        case (durum_q)
            Yukle: begin
                bus.yukle_hazir = 1'b1;
                dizi_yaz_adres  = sayac_q[IDX_BIT-1:0];
                dizi_yaz_veri   = bus.yukle_veri;
                dizi_yaz        = kabul;
                if (kabul) begin
                    sayac_d = sayac_q + SAYAC_BIT'(1);
                end
            end
            Calis: begin
                if (aralikta) begin
                    dizi_yaz = bus.bellek_yaz;
                end else begin
                    hata_d = 1'b1;
                    if (!hata_q) begin
                        hata_adres_d = bus.bellek_adres;
                    end
                end
            end
            default: ;
        endcase
    end

    bellek_dizisi #(
        .DERINLIK (KELIME_SAYISI),
        .VERI_BIT (VERI_BIT),
        .IDX_BIT  (IDX_BIT)
    ) u_dizi (
        .clk       (clk),
        .yaz       (dizi_yaz),
        .yaz_adres (dizi_yaz_adres),
        .yaz_veri  (dizi_yaz_veri),
        .oku_adres (idx),
        .oku_veri  (dizi_oku_veri)
    );

    assign bus.bellek_oku_veri = aralikta ? dizi_oku_veri : '0;

    assign islemci_rst     = islemci_rst_q;
    assign yuklenen_kelime = sayac_q;
    assign adres_hata      = hata_q;
    assign hata_adres      = hata_adres_q;

endmodule

// File: tb/tb_bellek_birimi.sv
// tb_bellek_birimi: self-checking bench for bellek_birimi (16-word instance).
module tb_bellek_birimi;

    localparam int unsigned K    = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] UST  = 32'h8000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irst;
    logic [4:0]  ykel;
    logic        hata;
    logic [31:0] hadr;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_durum;
    int          m_cnt;
    logic        m_irst;
    logic        m_hata;
    logic [31:0] m_hadr;
    logic [31:0] exp_mem [K];
    logic [31:0] sb [$];

    // Copies of the values driven for the current cycle.
    logic        d_v, d_s, d_yaz;
    logic [31:0] d_d, d_adr, d_yv;

    bellek_birimi_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

    bellek_birimi #(.KELIME_SAYISI(K)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .islemci_rst     (irst),
        .yuklenen_kelime (ykel),
        .adres_hata      (hata),
        .hata_adres      (hadr)
    );

    always #5 clk = ~clk;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (a < UST);
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic s,
                         input logic [31:0] adr, input logic yaz, input logic [31:0] yv);
        bus.yukle_gecerli   = v;   d_v   = v;
        bus.yukle_veri      = d;   d_d   = d;
        bus.yukle_son       = s;   d_s   = s;
        bus.bellek_adres    = adr; d_adr = adr;
        bus.bellek_yaz      = yaz; d_yaz = yaz;
        bus.bellek_yaz_veri = yv;  d_yv  = yv;
    endtask

    // Advance one rising edge and update the model with the driven values.
    task automatic clock();
        logic [31:0] o;
        @(posedge clk);
        case (m_durum)
            0: begin
                if (d_v) begin
                    exp_mem[m_cnt] = d_d;
                    sb.push_back(d_d);
                    m_cnt++;
                    if (d_s || m_cnt == K) m_durum = 1;
                end
            end
            1: m_durum = 2;
            default: begin
                if (!in_range(d_adr)) begin
                    if (!m_hata) m_hadr = d_adr;
                    m_hata = 1'b1;
                end else if (d_yaz) begin
                    o = d_adr - BASE;
                    exp_mem[o[5:2]] = d_yv;
                end
            end
        endcase
        m_irst = (m_durum != 2);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, BASE, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        m_durum = 0; m_cnt = 0; m_irst = 1'b1; m_hata = 1'b0; m_hadr = '0;
        sb.delete();
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.yukle_hazir !== 1'b1) begin errors++; $display("FAIL reset_hazir: got %b want 1", bus.yukle_hazir); end
        checks++; if (irst !== 1'b1) begin errors++; $display("FAIL reset_irst: got %b want 1", irst); end
        checks++; if (ykel !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ykel); end
        checks++; if (hata !== 1'b0) begin errors++; $display("FAIL reset_hata: got %b want 0", hata); end
        checks++; if (hadr !== 32'h0) begin errors++; $display("FAIL reset_hadr: got %h want 0", hadr); end
        clock();
    endtask

    task automatic test_load_run();
        logic [31:0] w [4];
        logic [31:0] beklenen;
        int i;
        w = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        for (int n = 0; n < 4; n++) begin
            drive(1, w[n], (n == 3), BASE, 0, 0);
            @(negedge clk);
            checks++; if (bus.yukle_hazir !== 1'b1) begin errors++; $display("FAIL load_hazir[%0d]: got %b want 1", n, bus.yukle_hazir); end
            clock();
        end
        checks++; if (ykel !== 5'd4) begin errors++; $display("FAIL load_count: got %0d want 4", ykel); end
        checks++; if (irst !== 1'b1) begin errors++; $display("FAIL birak_irst: got %b want 1", irst); end
        checks++; if (bus.yukle_hazir !== 1'b0) begin errors++; $display("FAIL birak_hazir: got %b want 0", bus.yukle_hazir); end
        // A word offered during the release cycle must not be taken.
        drive(1, 32'hFFFF_FFFF, 1, BASE, 0, 0);
        clock();
        checks++; if (irst !== 1'b0) begin errors++; $display("FAIL calis_irst: got %b want 0", irst); end
        checks++; if (ykel !== 5'd4) begin errors++; $display("FAIL calis_count: got %0d want 4", ykel); end
        drive(0, 0, 0, BASE + 32'h8, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'h3333_0002) begin errors++; $display("FAIL read_word2: got %h want 33330002", bus.bellek_oku_veri); end
        clock();
        i = 0;
        while (sb.size() > 0) begin
            beklenen = sb.pop_front();
            drive(0, 0, 0, BASE + 32'(4 * i), 0, 0);
            @(negedge clk);
            checks++; if (bus.bellek_oku_veri !== beklenen) begin errors++; $display("FAIL load_sb[%0d]: got %h want %h", i, bus.bellek_oku_veri, beklenen); end
            clock();
            i++;
        end
    endtask

    task automatic test_core_write();
        drive(0, 0, 0, BASE + 32'h10, 1, 32'hDEAD_BEEF);
        clock();
        drive(0, 0, 0, BASE + 32'h10, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_read: got %h want deadbeef", bus.bellek_oku_veri); end
        clock();
        // Same-cycle read sees the old word.
        drive(0, 0, 0, BASE + 32'h8, 1, 32'h5555_AAAA);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'h3333_0002) begin errors++; $display("FAIL write_old: got %h want 33330002", bus.bellek_oku_veri); end
        clock();
        drive(0, 0, 0, BASE + 32'h8, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'h5555_AAAA) begin errors++; $display("FAIL write_new: got %h want 5555aaaa", bus.bellek_oku_veri); end
        clock();
        // Last in-range word, then a misaligned read of it.
        drive(0, 0, 0, BASE + 32'h3C, 1, 32'h0000_F00F);
        clock();
        drive(0, 0, 0, BASE + 32'h3E, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'h0000_F00F) begin errors++; $display("FAIL top_word: got %h want 0000f00f", bus.bellek_oku_veri); end
        checks++; if (hata !== 1'b0) begin errors++; $display("FAIL inrange_hata: got %b want 0", hata); end
        clock();
    endtask

    task automatic test_errors();
        drive(0, 0, 0, 32'h7FFF_FFFC, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'h0) begin errors++; $display("FAIL low_read: got %h want 0", bus.bellek_oku_veri); end
        clock();
        drive(0, 0, 0, 32'h9000_0000, 1, 32'h1234_5678);
        @(negedge clk);
        checks++; if (hata !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", hata); end
        checks++; if (hadr !== 32'h7FFF_FFFC) begin errors++; $display("FAIL err_addr: got %h want 7ffffffc", hadr); end
        checks++; if (bus.bellek_oku_veri !== 32'h0) begin errors++; $display("FAIL high_read: got %h want 0", bus.bellek_oku_veri); end
        clock();
        drive(0, 0, 0, UST, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'h0) begin errors++; $display("FAIL edge_read: got %h want 0", bus.bellek_oku_veri); end
        clock();
        drive(0, 0, 0, BASE + 32'h10, 0, 0);
        @(negedge clk);
        checks++; if (hadr !== m_hadr) begin errors++; $display("FAIL err_sticky: got %h want %h", hadr, m_hadr); end
        checks++; if (bus.bellek_oku_veri !== exp_mem[4]) begin errors++; $display("FAIL err_mem: got %h want %h", bus.bellek_oku_veri, exp_mem[4]); end
        clock();
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] beklenen;
        int i;
        do_reset();
        @(negedge clk);
        checks++; if (hata !== 1'b0) begin errors++; $display("FAIL rst_hata: got %b want 0", hata); end
        checks++; if (hadr !== 32'h0) begin errors++; $display("FAIL rst_hadr: got %h want 0", hadr); end
        clock();
        // Core writes during loading must be ignored.
        for (int n = 0; n < 3; n++) begin
            drive(1, 32'hA000_0000 + 32'(n), 0, BASE + 32'h10, 1, 32'h0BAD_F00D);
            clock();
        end
        checks++; if (ykel !== 5'd3) begin errors++; $display("FAIL partial_count: got %0d want 3", ykel); end
        do_reset();
        for (int n = 0; n < 2; n++) begin
            drive(1, 32'hB000_0000 + 32'(n), (n == 1), BASE, 0, 0);
            clock();
        end
        drive(0, 0, 0, BASE, 0, 0);
        clock();
        checks++; if (ykel !== 5'd2) begin errors++; $display("FAIL reload_count: got %0d want 2", ykel); end
        checks++; if (hata !== 1'b0) begin errors++; $display("FAIL reload_hata: got %b want 0", hata); end
        checks++; if (irst !== 1'b0) begin errors++; $display("FAIL reload_irst: got %b want 0", irst); end
        drive(0, 0, 0, BASE + 32'h10, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'hDEAD_BEEF) begin errors++; $display("FAIL yukle_yaz: got %h want deadbeef", bus.bellek_oku_veri); end
        clock();
        drive(0, 0, 0, BASE + 32'h8, 0, 0);
        @(negedge clk);
        checks++; if (bus.bellek_oku_veri !== 32'hA000_0002) begin errors++; $display("FAIL kept_word2: got %h want a0000002", bus.bellek_oku_veri); end
        clock();
        i = 0;
        while (sb.size() > 0) begin
            beklenen = sb.pop_front();
            drive(0, 0, 0, BASE + 32'(4 * i), 0, 0);
            @(negedge clk);
            checks++; if (bus.bellek_oku_veri !== beklenen) begin errors++; $display("FAIL reload_sb[%0d]: got %h want %h", i, bus.bellek_oku_veri, beklenen); end
            clock();
            i++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] beklenen;
        logic        v;
        int n;
        int i;
        int cyc;
        do_reset();
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            v = 1'($urandom_range(0, 1));
            drive(v, 32'hC000_0000 + 32'(n), (n == 9), BASE, 0, 0);
            @(negedge clk);
            checks++; if (bus.yukle_hazir !== 1'b1) begin errors++; $display("FAIL bp_hazir: got %b want 1", bus.yukle_hazir); end
            checks++; if (ykel !== 5'(m_cnt)) begin errors++; $display("FAIL bp_count: got %0d want %0d", ykel, m_cnt); end
            clock();
            if (v) n++;
            cyc++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL bp_timeout: got %0d words want 10", n); end
        drive(0, 0, 0, BASE, 0, 0);
        clock();
        checks++; if (ykel !== 5'd10) begin errors++; $display("FAIL bp_total: got %0d want 10", ykel); end
        i = 0;
        while (sb.size() > 0) begin
            beklenen = sb.pop_front();
            drive(0, 0, 0, BASE + 32'(4 * i), 0, 0);
            @(negedge clk);
            checks++; if (bus.bellek_oku_veri !== beklenen) begin errors++; $display("FAIL bp_sb[%0d]: got %h want %h", i, bus.bellek_oku_veri, beklenen); end
            clock();
            i++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] beklenen;
        int i;
        do_reset();
        for (int n = 0; n < int'(K) + 4; n++) begin
            drive(1, 32'hD000_0000 + 32'(n), 0, BASE, 0, 0);
            @(negedge clk);
            checks++; if (bus.yukle_hazir !== (m_durum == 0)) begin errors++; $display("FAIL ovf_hazir[%0d]: got %b want %b", n, bus.yukle_hazir, (m_durum == 0)); end
            clock();
        end
        checks++; if (ykel !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", ykel); end
        checks++; if (bus.yukle_hazir !== 1'b0) begin errors++; $display("FAIL ovf_hazir_end: got %b want 0", bus.yukle_hazir); end
        checks++; if (irst !== 1'b0) begin errors++; $display("FAIL ovf_irst: got %b want 0", irst); end
        i = 0;
        while (sb.size() > 0) begin
            beklenen = sb.pop_front();
            drive(0, 0, 0, BASE + 32'(4 * i), 0, 0);
            @(negedge clk);
            checks++; if (bus.bellek_oku_veri !== beklenen) begin errors++; $display("FAIL ovf_sb[%0d]: got %h want %h", i, bus.bellek_oku_veri, beklenen); end
            clock();
            i++;
        end
    endtask

    initial begin
        drive(0, 0, 0, BASE, 0, 0);
        test_reset();
        test_load_run();
        test_core_write();
        test_errors();
        test_reset_mid_load();
        test_backpressure();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
